axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_resp_timer.sv | 29 ++
 rtl/axil_cmd_master.sv | 163 ++++++++++++++++
 tb/tb_axil_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encoding,
// response codes and the fixed protection value.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_resp_timer.sv
// Response-wait timer for axil_cmd_master; only built when AXIL_MASTER_TIMEOUT_EN
// is defined. Counts consecutive waiting cycles and flags the last allowed one.
`ifdef AXIL_MASTER_TIMEOUT_EN
module axil_resp_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Restarts from zero whenever the master is not waiting on a response.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expired = active && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Optional response timeout is enabled with AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                          m_aclk,
  input  logic                          m_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]                    m_awprot,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_wdata,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]                    m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  axil_state_t                   state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    resp_q;
  logic                          timeout_hit;

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_awprot = PROT_DEFAULT;
  assign m_arprot = PROT_DEFAULT;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic timer_active;

  assign timer_active = (state == WR_RESP && !m_bvalid) || (state == RD_RESP && !m_rvalid);

  axil_resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_resp_timer (
    .clk    (m_aclk),
    .rst_n  (m_aresetn),
    .active (timer_active),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Response fields are staged in rdata_q/resp_q and published one cycle after DONE.
  always_ff @(posedge m_aclk) begin
    if (!m_aresetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            if (cmd_write) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              m_arvalid <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        // AW and W complete independently; a channel already done counts as ready.
        WR_REQ: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready) m_wvalid <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            resp_q   <= m_bresp;
            state    <= DONE;
          end else if (timeout_hit) begin
            m_bready <= 1'b0;
            resp_q   <= RESP_SLVERR;
            state    <= DONE;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            rdata_q  <= m_rdata;
            resp_q   <= m_rresp;
            state    <= DONE;
          end else if (timeout_hit) begin
            m_rready <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= RESP_SLVERR;
            state    <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rdata_q;
          rsp_resp  <= resp_q;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed self-checking bench for axil_cmd_master; the timeout scenario follows
// AXIL_MASTER_TIMEOUT_EN so the same file covers both builds.
module tb_axil_cmd_master;

  logic        m_aclk = 1'b0;
  logic        m_aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [3:0]  m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  int compared   = 0;
  int mismatched = 0;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .m_aclk   (m_aclk),
    .m_aresetn(m_aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .m_awaddr (m_awaddr),
    .m_awprot (m_awprot),
    .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata  (m_wdata),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_bresp  (m_bresp),
    .m_bvalid (m_bvalid),
    .m_bready (m_bready),
    .m_araddr (m_araddr),
    .m_arprot (m_arprot),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready)
  );

  always #5 m_aclk = ~m_aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single cycle; returns at the negedge of the cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] data);
    checkOutput("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    @(negedge m_aclk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    m_aresetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bresp   = 2'b00;
    m_bvalid  = 1'b0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rvalid  = 1'b0;

    repeat (3) @(negedge m_aclk);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_awvalid", m_awvalid, 0);
    checkOutput("reset_wvalid", m_wvalid, 0);
    checkOutput("reset_arvalid", m_arvalid, 0);
    checkOutput("reset_bready", m_bready, 0);
    checkOutput("reset_rready", m_rready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_resp", rsp_resp, 0);
    checkOutput("reset_awaddr", m_awaddr, 0);
    m_aresetn = 1'b1;
    @(negedge m_aclk);
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);

    $display("[TB] write 0xDEADBEEF to 0x4, zero-wait slave");
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    m_bresp   = 2'b00;
    applyStimulus(1'b1, 4'h4, 32'hDEAD_BEEF);
    checkOutput("w1_awvalid_n1", m_awvalid, 1);
    checkOutput("w1_wvalid_n1", m_wvalid, 1);
    checkOutput("w1_awaddr_n1", m_awaddr, 32'h4);
    checkOutput("w1_wdata_n1", m_wdata, 32'hDEAD_BEEF);
    checkOutput("w1_awprot", m_awprot, 0);
    checkOutput("w1_cmd_ready_n1", cmd_ready, 0);
    @(negedge m_aclk);
    checkOutput("w1_awvalid_n2", m_awvalid, 0);
    checkOutput("w1_wvalid_n2", m_wvalid, 0);
    checkOutput("w1_bready_n2", m_bready, 1);
    checkOutput("w1_rsp_valid_n2", rsp_valid, 0);
    @(negedge m_aclk);
    checkOutput("w1_bready_n3", m_bready, 0);
    checkOutput("w1_rsp_valid_n3", rsp_valid, 0);
    @(negedge m_aclk);
    checkOutput("w1_rsp_valid_n4", rsp_valid, 1);
    checkOutput("w1_rsp_resp_n4", rsp_resp, 2'b00);
    checkOutput("w1_rsp_rdata_n4", rsp_rdata, 0);
    @(negedge m_aclk);
    checkOutput("w1_rsp_valid_n5", rsp_valid, 0);
    m_bvalid = 1'b0;

    $display("[TB] write with AW stalled until N+4, BRESP=SLVERR");
    m_awready = 1'b0;
    m_wready  = 1'b1;
    applyStimulus(1'b1, 4'h4, 32'h1234_5678);
    checkOutput("w2_awvalid_n1", m_awvalid, 1);
    checkOutput("w2_wvalid_n1", m_wvalid, 1);
    @(negedge m_aclk);
    checkOutput("w2_wvalid_n2", m_wvalid, 0);
    checkOutput("w2_awvalid_n2", m_awvalid, 1);
    checkOutput("w2_awaddr_n2", m_awaddr, 32'h4);
    checkOutput("w2_bready_n2", m_bready, 0);
    @(negedge m_aclk);
    checkOutput("w2_awvalid_n3", m_awvalid, 1);
    checkOutput("w2_awaddr_n3", m_awaddr, 32'h4);
    @(negedge m_aclk);
    checkOutput("w2_awvalid_n4", m_awvalid, 1);
    m_awready = 1'b1;
    @(negedge m_aclk);
    checkOutput("w2_awvalid_n5", m_awvalid, 0);
    checkOutput("w2_bready_n5", m_bready, 1);
    checkOutput("w2_rsp_valid_n5", rsp_valid, 0);
    m_bresp  = 2'b10;
    m_bvalid = 1'b1;
    @(negedge m_aclk);
    checkOutput("w2_bready_n6", m_bready, 0);
    checkOutput("w2_rsp_valid_n6", rsp_valid, 0);
    m_bvalid  = 1'b0;
    m_awready = 1'b0;
    @(negedge m_aclk);
    checkOutput("w2_rsp_valid_n7", rsp_valid, 1);
    checkOutput("w2_rsp_resp_n7", rsp_resp, 2'b10);
    @(negedge m_aclk);
    checkOutput("w2_rsp_valid_n8", rsp_valid, 0);

    $display("[TB] read 0x8 returning 0x00000008/OKAY");
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h0000_0008;
    m_rresp   = 2'b00;
    applyStimulus(1'b0, 4'h8, 32'hFFFF_FFFF);
    checkOutput("r1_arvalid_n1", m_arvalid, 1);
    checkOutput("r1_araddr_n1", m_araddr, 32'h8);
    checkOutput("r1_arprot", m_arprot, 0);
    checkOutput("r1_awvalid_n1", m_awvalid, 0);
    checkOutput("r1_cmd_ready_n1", cmd_ready, 0);
    @(negedge m_aclk);
    checkOutput("r1_arvalid_n2", m_arvalid, 0);
    checkOutput("r1_rready_n2", m_rready, 1);
    checkOutput("r1_cmd_ready_n2", cmd_ready, 0);
    @(negedge m_aclk);
    checkOutput("r1_rready_n3", m_rready, 0);
    checkOutput("r1_cmd_ready_n3", cmd_ready, 0);
    checkOutput("r1_rsp_valid_n3", rsp_valid, 0);
    @(negedge m_aclk);
    checkOutput("r1_rsp_valid_n4", rsp_valid, 1);
    checkOutput("r1_rsp_rdata_n4", rsp_rdata, 32'h0000_0008);
    checkOutput("r1_rsp_resp_n4", rsp_resp, 2'b00);
    @(negedge m_aclk);
    checkOutput("r1_rsp_valid_n5", rsp_valid, 0);

    $display("[TB] command held valid while busy is taken only back in IDLE");
    m_rdata   = 32'h0000_00C0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    m_bresp   = 2'b00;
    applyStimulus(1'b0, 4'hC, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h2;
    cmd_wdata = 32'h1111_2222;
    checkOutput("b_araddr_n1", m_araddr, 32'hC);
    @(negedge m_aclk);
    checkOutput("b_awvalid_n2", m_awvalid, 0);
    checkOutput("b_cmd_ready_n2", cmd_ready, 0);
    @(negedge m_aclk);
    checkOutput("b_awvalid_n3", m_awvalid, 0);
    @(negedge m_aclk);
    checkOutput("b_rsp_valid_n4", rsp_valid, 1);
    checkOutput("b_rsp_rdata_n4", rsp_rdata, 32'h0000_00C0);
    checkOutput("b_cmd_ready_n4", cmd_ready, 1);
    @(negedge m_aclk);
    cmd_valid = 1'b0;
    m_rvalid  = 1'b0;
    checkOutput("b_awvalid_n5", m_awvalid, 1);
    checkOutput("b_awaddr_n5", m_awaddr, 32'h2);
    checkOutput("b_wdata_n5", m_wdata, 32'h1111_2222);
    @(negedge m_aclk);
    checkOutput("b_bready_n6", m_bready, 1);
    @(negedge m_aclk);
    @(negedge m_aclk);
    checkOutput("b_rsp_valid_n8", rsp_valid, 1);
    checkOutput("b_rsp_rdata_n8", rsp_rdata, 0);
    @(negedge m_aclk);
    checkOutput("b_rsp_valid_n9", rsp_valid, 0);
    m_bvalid = 1'b0;

    $display("[TB] reset asserted while waiting in WR_RESP");
    applyStimulus(1'b1, 4'hA, 32'hCAFE_F00D);
    checkOutput("rst_awvalid_n1", m_awvalid, 1);
    @(negedge m_aclk);
    checkOutput("rst_bready_n2", m_bready, 1);
    m_aresetn = 1'b0;
    m_bvalid  = 1'b1;
    @(negedge m_aclk);
    checkOutput("rst_bready_n3", m_bready, 0);
    checkOutput("rst_awvalid_n3", m_awvalid, 0);
    checkOutput("rst_wvalid_n3", m_wvalid, 0);
    checkOutput("rst_arvalid_n3", m_arvalid, 0);
    checkOutput("rst_rready_n3", m_rready, 0);
    checkOutput("rst_rsp_valid_n3", rsp_valid, 0);
    checkOutput("rst_cmd_ready_n3", cmd_ready, 0);
    checkOutput("rst_awaddr_n3", m_awaddr, 0);
    checkOutput("rst_wdata_n3", m_wdata, 0);
    m_aresetn = 1'b1;
    @(negedge m_aclk);
    checkOutput("rst_cmd_ready_n4", cmd_ready, 1);
    checkOutput("rst_rsp_valid_n4", rsp_valid, 0);
    m_bvalid = 1'b0;
    @(negedge m_aclk);
    checkOutput("rst_rsp_valid_n5", rsp_valid, 0);

    $display("[TB] read with a slave that never returns data");
    m_arready = 1'b1;
    m_rvalid  = 1'b0;
    m_rdata   = 32'hBAD0_BAD0;
    m_rresp   = 2'b00;
    applyStimulus(1'b0, 4'h8, 32'h0);
    @(negedge m_aclk);
    checkOutput("to_rready_n2", m_rready, 1);
    pulses = 0;
`ifdef AXIL_MASTER_TIMEOUT_EN
    repeat (15) begin
      @(negedge m_aclk);
      if (rsp_valid) pulses++;
    end
    checkOutput("to_early_pulses", pulses, 0);
    checkOutput("to_rready_n17", m_rready, 1);
    @(negedge m_aclk);
    checkOutput("to_rready_n18", m_rready, 0);
    checkOutput("to_rsp_valid_n18", rsp_valid, 0);
    @(negedge m_aclk);
    checkOutput("to_rsp_valid_n19", rsp_valid, 1);
    checkOutput("to_rsp_resp_n19", rsp_resp, 2'b10);
    checkOutput("to_rsp_rdata_n19", rsp_rdata, 0);
    @(negedge m_aclk);
    checkOutput("to_rsp_valid_n20", rsp_valid, 0);
`else
    repeat (30) begin
      @(negedge m_aclk);
      if (rsp_valid) pulses++;
    end
    checkOutput("nto_pulses", pulses, 0);
    checkOutput("nto_rready_still", m_rready, 1);
    m_rvalid = 1'b1;
    m_rdata  = 32'h1357_2468;
    @(negedge m_aclk);
    checkOutput("nto_rready_done", m_rready, 0);
    m_rvalid = 1'b0;
    @(negedge m_aclk);
    checkOutput("nto_rsp_valid", rsp_valid, 1);
    checkOutput("nto_rsp_rdata", rsp_rdata, 32'h1357_2468);
    checkOutput("nto_rsp_resp", rsp_resp, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
